// File: rtl/bpu_sram_ctrl.sv
// Sequencer/arbiter for a single-port BPU table SRAM: clears the array after reset,
// then serves predictor reads with priority over a one-entry buffered update write.
module bpu_sram_ctrl #(
    parameter int SETS       = 512,
    parameter int ADDR_W     = 9,
    parameter int WAYS       = 4,
    parameter int WAY_W      = 80,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    r_req_valid,
    output logic                    r_req_ready,
    input  logic [ADDR_W-1:0]       r_req_setIdx,
    output logic                    r_resp_valid,
    output logic [WAYS*WAY_W-1:0]   r_resp_data,
    input  logic                    w_req_valid,
    output logic                    w_req_ready,
    input  logic [ADDR_W-1:0]       w_req_setIdx,
    input  logic [WAYS*WAY_W-1:0]   w_req_data,
    input  logic [WAYS-1:0]         w_req_mask,
    output logic                    init_done,
    output logic                    sram_addr_unused_guard,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic                    sram_en,
    output logic                    sram_wmode,
    output logic [WAYS-1:0]         sram_wmask,
    output logic [WAYS*WAY_W-1:0]   sram_wdata,
    input  logic [WAYS*WAY_W-1:0]   sram_rdata,
    output logic                    dbg_state
);
    localparam int DATA_W = WAYS * WAY_W;
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(SETS - 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_setIdx;
    logic [DATA_W-1:0]   wb_data;
    logic [WAYS-1:0]     wb_mask;
    logic [CNT_W-1:0]    starve_cnt;
    logic                resp_q;

    logic run, sweep, forced_w, hazard, drain_now, read_go, w_acc;

    // Handshakes: a transfer happens in a cycle where valid && ready are both high;
    // ready never depends on anything but state and the current request fields.
    assign run       = (state == ST_RUN) && !reset;
    assign sweep     = (state == ST_INIT) && !reset;
    assign forced_w  = wb_valid && (starve_cnt == STARVE_LIM);
    assign hazard    = r_req_valid && wb_valid && (r_req_setIdx == wb_setIdx);
    assign drain_now = run && wb_valid && (forced_w || hazard || !r_req_valid);
    assign read_go   = run && r_req_valid && !forced_w && !hazard;
    assign w_acc     = w_req_valid && w_req_ready;

    assign r_req_ready  = run && !forced_w && !hazard;
    assign w_req_ready  = run && (!wb_valid || drain_now);
    assign r_resp_valid = resp_q && !reset;
    assign r_resp_data  = sram_rdata;
    assign init_done    = run;
    assign dbg_state    = state;
    assign sram_addr_unused_guard = 1'b0;

    // One SRAM access per cycle; idle fields are driven to zero.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (sweep) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = idx;
            sram_wmask = '1;
        end else if (drain_now) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = wb_setIdx;
            sram_wmask = wb_mask;
            sram_wdata = wb_data;
        end else if (read_go) begin
            sram_en    = 1'b1;
            sram_addr  = r_req_setIdx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_INIT;
            idx        <= '0;
            wb_valid   <= 1'b0;
            wb_setIdx  <= '0;
            wb_data    <= '0;
            wb_mask    <= '0;
            starve_cnt <= '0;
            resp_q     <= 1'b0;
        end else begin
            resp_q <= read_go;
            case (state)
                ST_INIT: begin
                    // Hold idx at the last set so the sweep cannot restart.
                    if (idx == LAST_IDX) state <= ST_RUN;
                    else                 idx   <= idx + 1'b1;
                end
                ST_RUN: begin
                    if (w_acc) begin
                        wb_valid  <= 1'b1;
                        wb_setIdx <= w_req_setIdx;
                        wb_data   <= w_req_data;
                        wb_mask   <= w_req_mask;
                    end else if (drain_now) begin
                        wb_valid  <= 1'b0;
                    end
                    if (!wb_valid || drain_now)      starve_cnt <= '0;
                    else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
                end
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_bpu_sram_ctrl.sv
// Directed bench for bpu_sram_ctrl with a behavioural one-cycle-latency masked SRAM.
module tb_bpu_sram_ctrl;
    logic           clock = 1'b0;
    logic           reset;
    logic           r_req_valid;
    logic           r_req_ready;
    logic [8:0]     r_req_setIdx;
    logic           r_resp_valid;
    logic [319:0]   r_resp_data;
    logic           w_req_valid;
    logic           w_req_ready;
    logic [8:0]     w_req_setIdx;
    logic [319:0]   w_req_data;
    logic [3:0]     w_req_mask;
    logic           init_done;
    logic           guard;
    logic [8:0]     sram_addr;
    logic           sram_en;
    logic           sram_wmode;
    logic [3:0]     sram_wmask;
    logic [319:0]   sram_wdata;
    logic [319:0]   sram_rdata = '0;
    logic           dbg_state;

    int errors = 0;
    int checks = 0;
    logic w11_seen = 1'b0;
    logic [319:0] mem [0:511];

    always #5 clock = ~clock;

    bpu_sram_ctrl dut (
        .clock(clock), .reset(reset),
        .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_setIdx(r_req_setIdx),
        .r_resp_valid(r_resp_valid), .r_resp_data(r_resp_data),
        .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_setIdx(w_req_setIdx),
        .w_req_data(w_req_data), .w_req_mask(w_req_mask),
        .init_done(init_done), .sram_addr_unused_guard(guard),
        .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .dbg_state(dbg_state)
    );

    // SRAM macro model, preloaded with garbage so the clear sweep matters.
    initial for (int i = 0; i < 512; i++) mem[i] = {10{32'hDEADBEEF}};

    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int w = 0; w < 4; w++)
                    if (sram_wmask[w]) mem[sram_addr][w*80 +: 80] <= sram_wdata[w*80 +: 80];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
        if (sram_en && sram_wmode && sram_addr == 9'd11 && sram_wdata != '0) w11_seen <= 1'b1;
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        r_req_valid = 1'b0; r_req_setIdx = '0;
        w_req_valid = 1'b0; w_req_setIdx = '0; w_req_data = '0; w_req_mask = '0;
    endtask

    // Walks a full clear sweep from the current cycle, counting cycles that deviate.
    task automatic do_sweep(output int bad);
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_wmask !== 4'hF ||
                sram_wdata !== 320'h0 || sram_addr !== k[8:0] || r_req_ready !== 1'b0 ||
                w_req_ready !== 1'b0 || init_done !== 1'b0) bad++;
            next_cycle();
            settle();
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            next_cycle(); settle();
            checks++; if (r_req_ready !== 1'b0 || w_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got r=%0b w=%0b want 0 0", r_req_ready, w_req_ready); end
            checks++; if (init_done !== 1'b0 || r_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_status: got done=%0b resp=%0b want 0 0", init_done, r_resp_valid); end
            checks++; if (sram_en !== 1'b0 || dbg_state !== 1'b0) begin errors++; $display("FAIL reset_sram: got en=%0b st=%0b want 0 0", sram_en, dbg_state); end
        end
        reset = 1'b0;
        settle();
        checks++; if (sram_en !== 1'b1 || sram_addr !== 9'd0 || dbg_state !== 1'b0) begin errors++; $display("FAIL sweep_first: got en=%0b addr=%0d st=%0b want 1 0 0", sram_en, sram_addr, dbg_state); end
        do_sweep(bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL sweep_seq: got %0d bad cycles want 0", bad); end
        checks++; if (init_done !== 1'b1 || dbg_state !== 1'b1) begin errors++; $display("FAIL init_done: got done=%0b st=%0b want 1 1", init_done, dbg_state); end
        checks++; if (r_req_ready !== 1'b1 || w_req_ready !== 1'b1) begin errors++; $display("FAIL run_ready: got r=%0b w=%0b want 1 1", r_req_ready, w_req_ready); end
        r_req_valid = 1'b1; r_req_setIdx = 9'd7;
        settle();
        checks++; if (sram_en !== 1'b1 || sram_wmode !== 1'b0 || sram_addr !== 9'd7) begin errors++; $display("FAIL read7_issue: got en=%0b wm=%0b addr=%0d want 1 0 7", sram_en, sram_wmode, sram_addr); end
        next_cycle(); r_req_valid = 1'b0; settle();
        checks++; if (r_resp_valid !== 1'b1 || r_resp_data !== 320'h0) begin errors++; $display("FAIL read7_data: got v=%0b d=%0h want 1 0", r_resp_valid, r_resp_data); end
    endtask

    task automatic test_read_pipeline();
        logic [319:0] a5;
        a5 = {40{8'hA5}};
        next_cycle();
        w_req_valid = 1'b1; w_req_setIdx = 9'd5; w_req_data = a5; w_req_mask = 4'hF;
        settle();
        checks++; if (w_req_ready !== 1'b1) begin errors++; $display("FAIL rp_wready: got %0b want 1", w_req_ready); end
        next_cycle(); idle_inputs(); settle();
        checks++; if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 9'd5 || sram_wmask !== 4'hF) begin errors++; $display("FAIL rp_drain: got en=%0b wm=%0b addr=%0d mask=%0h want 1 1 5 f", sram_en, sram_wmode, sram_addr, sram_wmask); end
        next_cycle(); r_req_valid = 1'b1; r_req_setIdx = 9'd5; settle();
        checks++; if (r_req_ready !== 1'b1) begin errors++; $display("FAIL rp_ready: got %0b want 1", r_req_ready); end
        next_cycle(); r_req_setIdx = 9'd6; settle();
        checks++; if (r_resp_valid !== 1'b1 || r_resp_data !== a5) begin errors++; $display("FAIL rp_resp0: got v=%0b d=%0h want 1 a5..", r_resp_valid, r_resp_data); end
        next_cycle(); r_req_setIdx = 9'd5; settle();
        checks++; if (r_resp_valid !== 1'b1 || r_resp_data !== 320'h0) begin errors++; $display("FAIL rp_resp1: got v=%0b d=%0h want 1 0", r_resp_valid, r_resp_data); end
        next_cycle(); r_req_valid = 1'b0; settle();
        checks++; if (r_resp_valid !== 1'b1 || r_resp_data !== a5) begin errors++; $display("FAIL rp_resp2: got v=%0b d=%0h want 1 a5..", r_resp_valid, r_resp_data); end
        next_cycle(); settle();
        checks++; if (r_resp_valid !== 1'b0) begin errors++; $display("FAIL rp_resp_end: got %0b want 0", r_resp_valid); end
    endtask

    task automatic test_hazard();
        logic [319:0] hd, exp_d;
        hd    = {{20{4'h4}}, {20{4'h3}}, {20{4'h2}}, {20{4'h1}}};
        exp_d = {160'h0, {20{4'h2}}, 80'h0};
        next_cycle();
        r_req_valid = 1'b1; r_req_setIdx = 9'd8;
        w_req_valid = 1'b1; w_req_setIdx = 9'd9; w_req_data = hd; w_req_mask = 4'b0010;
        settle();
        checks++; if (r_req_ready !== 1'b1 || w_req_ready !== 1'b1 || sram_wmode !== 1'b0 || sram_addr !== 9'd8) begin errors++; $display("FAIL hz_setup: got r=%0b w=%0b wm=%0b addr=%0d want 1 1 0 8", r_req_ready, w_req_ready, sram_wmode, sram_addr); end
        next_cycle(); w_req_valid = 1'b0; r_req_setIdx = 9'd9; settle();
        checks++; if (r_req_ready !== 1'b0) begin errors++; $display("FAIL hz_block: got r_ready=%0b want 0", r_req_ready); end
        checks++; if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 9'd9 || sram_wmask !== 4'b0010) begin errors++; $display("FAIL hz_write: got en=%0b wm=%0b addr=%0d mask=%0h want 1 1 9 2", sram_en, sram_wmode, sram_addr, sram_wmask); end
        next_cycle(); settle();
        checks++; if (r_req_ready !== 1'b1 || sram_wmode !== 1'b0 || sram_addr !== 9'd9) begin errors++; $display("FAIL hz_read: got r=%0b wm=%0b addr=%0d want 1 0 9", r_req_ready, sram_wmode, sram_addr); end
        next_cycle(); r_req_valid = 1'b0; settle();
        checks++; if (r_resp_valid !== 1'b1 || r_resp_data !== exp_d) begin errors++; $display("FAIL hz_data: got v=%0b d=%0h want 1 %0h", r_resp_valid, r_resp_data, exp_d); end
    endtask

    task automatic test_starvation();
        next_cycle();
        r_req_valid = 1'b1; r_req_setIdx = 9'd1;
        w_req_valid = 1'b1; w_req_setIdx = 9'd2; w_req_data = {10{32'h5A5A0002}}; w_req_mask = 4'hF;
        settle();
        checks++; if (r_req_ready !== 1'b1 || w_req_ready !== 1'b1) begin errors++; $display("FAIL st_accept: got r=%0b w=%0b want 1 1", r_req_ready, w_req_ready); end
        next_cycle(); w_req_valid = 1'b0; settle();
        for (int c = 1; c <= 4; c++) begin
            checks++; if (r_req_ready !== 1'b1 || sram_wmode !== 1'b0 || sram_addr !== 9'd1 || w_req_ready !== 1'b0) begin errors++; $display("FAIL st_blocked%0d: got r=%0b wm=%0b addr=%0d w=%0b want 1 0 1 0", c, r_req_ready, sram_wmode, sram_addr, w_req_ready); end
            next_cycle(); settle();
        end
        checks++; if (r_req_ready !== 1'b0 || sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 9'd2) begin errors++; $display("FAIL st_forced: got r=%0b en=%0b wm=%0b addr=%0d want 0 1 1 2", r_req_ready, sram_en, sram_wmode, sram_addr); end
        next_cycle(); settle();
        checks++; if (r_req_ready !== 1'b1 || sram_wmode !== 1'b0 || r_resp_valid !== 1'b0) begin errors++; $display("FAIL st_after: got r=%0b wm=%0b resp=%0b want 1 0 0", r_req_ready, sram_wmode, r_resp_valid); end
        r_req_valid = 1'b0;
    endtask

    task automatic test_replace_on_drain();
        logic [319:0] p4;
        p4 = {10{32'h44440004}};
        next_cycle();
        w_req_valid = 1'b1; w_req_setIdx = 9'd3; w_req_data = {10{32'h33330003}}; w_req_mask = 4'hF;
        settle();
        checks++; if (w_req_ready !== 1'b1 || sram_en !== 1'b0) begin errors++; $display("FAIL rd_first: got w=%0b en=%0b want 1 0", w_req_ready, sram_en); end
        next_cycle(); w_req_setIdx = 9'd4; w_req_data = p4; settle();
        checks++; if (w_req_ready !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 9'd3) begin errors++; $display("FAIL rd_replace: got w=%0b wm=%0b addr=%0d want 1 1 3", w_req_ready, sram_wmode, sram_addr); end
        next_cycle(); w_req_valid = 1'b0; settle();
        checks++; if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 9'd4 || sram_wdata !== p4) begin errors++; $display("FAIL rd_set4: got en=%0b wm=%0b addr=%0d want 1 1 4", sram_en, sram_wmode, sram_addr); end
        next_cycle(); settle();
        checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL rd_empty: got en=%0b want 0", sram_en); end
        w_req_valid = 1'b1; w_req_setIdx = 9'd5; w_req_data = '1; w_req_mask = 4'h0;
        next_cycle(); w_req_valid = 1'b0; settle();
        checks++; if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 9'd5 || sram_wmask !== 4'h0) begin errors++; $display("FAIL mask0_drain: got en=%0b wm=%0b addr=%0d mask=%0h want 1 1 5 0", sram_en, sram_wmode, sram_addr, sram_wmask); end
        next_cycle(); r_req_valid = 1'b1; r_req_setIdx = 9'd5; settle();
        next_cycle(); r_req_setIdx = 9'd4; settle();
        checks++; if (r_resp_valid !== 1'b1 || r_resp_data !== {40{8'hA5}}) begin errors++; $display("FAIL mask0_keep: got v=%0b d=%0h want 1 a5..", r_resp_valid, r_resp_data); end
        next_cycle(); r_req_valid = 1'b0; settle();
        checks++; if (r_resp_valid !== 1'b1 || r_resp_data !== p4) begin errors++; $display("FAIL rd_read4: got v=%0b d=%0h want 1 %0h", r_resp_valid, r_resp_data, p4); end
    endtask

    task automatic test_reset_mid();
        int bad;
        next_cycle(); reset = 1'b1; settle();
        next_cycle(); reset = 1'b0; settle();
        for (int c = 0; c < 200; c++) begin next_cycle(); settle(); end
        checks++; if (sram_en !== 1'b1 || sram_addr !== 9'd200) begin errors++; $display("FAIL mid_idx200: got en=%0b addr=%0d want 1 200", sram_en, sram_addr); end
        reset = 1'b1; settle();
        checks++; if (sram_en !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL mid_in_reset: got en=%0b done=%0b want 0 0", sram_en, init_done); end
        next_cycle(); reset = 1'b0; settle();
        checks++; if (sram_en !== 1'b1 || sram_addr !== 9'd0 || dbg_state !== 1'b0) begin errors++; $display("FAIL mid_restart: got en=%0b addr=%0d st=%0b want 1 0 0", sram_en, sram_addr, dbg_state); end
        do_sweep(bad);
        checks++; if (bad !== 0 || init_done !== 1'b1) begin errors++; $display("FAIL mid_sweep: got bad=%0d done=%0b want 0 1", bad, init_done); end
        r_req_valid = 1'b1; r_req_setIdx = 9'd10;
        w_req_valid = 1'b1; w_req_setIdx = 9'd11; w_req_data = {10{32'hCAFEF00D}}; w_req_mask = 4'hF;
        settle();
        checks++; if (r_req_ready !== 1'b1 || w_req_ready !== 1'b1) begin errors++; $display("FAIL mw_accept: got r=%0b w=%0b want 1 1", r_req_ready, w_req_ready); end
        next_cycle(); idle_inputs(); reset = 1'b1; settle();
        checks++; if (sram_en !== 1'b0 || r_resp_valid !== 1'b0) begin errors++; $display("FAIL mw_in_reset: got en=%0b resp=%0b want 0 0", sram_en, r_resp_valid); end
        next_cycle(); reset = 1'b0; settle();
        checks++; if (r_resp_valid !== 1'b0 || sram_addr !== 9'd0 || sram_wdata !== 320'h0 || dbg_state !== 1'b0) begin errors++; $display("FAIL mw_restart: got resp=%0b addr=%0d st=%0b want 0 0 0", r_resp_valid, sram_addr, dbg_state); end
        do_sweep(bad);
        checks++; if (bad !== 0 || w11_seen !== 1'b0) begin errors++; $display("FAIL mw_dropped: got bad=%0d w11=%0b want 0 0", bad, w11_seen); end
    endtask

    initial begin
        test_reset();
        test_read_pipeline();
        test_hazard();
        test_starvation();
        test_replace_on_drain();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
